// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
// State encoding, default operand width and requester id width.
package mul_seq_ctrl_pkg;

    localparam int MUL_W = 4;
    localparam int ID_W  = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_CAPT = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Counter width able to hold 0..w-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_rr_arb2.sv
// Two-input round-robin grant: prio picks the winner when both inputs are valid.
// Grants are only issued while advance is high; output is one-hot or zero.
module rr_arb2
    import mul_seq_ctrl_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       prio,
    input  logic       advance,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (advance) begin
            if (valid0 && valid1) begin
                grant = prio ? 2'b10 : 2'b01;
            end else if (valid0) begin
                grant = 2'b01;
            end else if (valid1) begin
                grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for a shared shift-add multiplier with two round-robin requesters.
// Optional MUL_EARLY_DONE_EN ends RUN as soon as the remaining multiplier bits are zero.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,
    output logic             mul_ld,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [W-1:0]     mul_rb,
    input  logic [2*W-1:0]   mul_ry,
    output logic             rsp_valid,
    output logic [ID_W-1:0]  rsp_id,
    output logic [2*W-1:0]   rsp_y,
    input  logic             rsp_ready,
    output logic             busy
);

    localparam int CNT_W = cnt_width(W);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                prio_q, prio_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [W-1:0]        mul_a_q, mul_a_d;
    logic [W-1:0]        mul_b_q, mul_b_d;
    logic                mul_ld_q, mul_ld_d;
    logic [2*W-1:0]      rsp_y_q, rsp_y_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;
    logic [1:0]          grant;
    logic                run_last;

    rr_arb2 u_arb (
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .prio    (prio_q),
        .advance (state_q == ST_IDLE),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

`ifdef MUL_EARLY_DONE_EN
    // No set bits left in the multiplier means no further adds can change ry.
    assign run_last = (cnt_q == CNT_W'(W - 1)) || (mul_rb == '0);
`else
    logic unused_rb;
    assign unused_rb = ^mul_rb;
    assign run_last  = (cnt_q == CNT_W'(W - 1));
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        id_d      = id_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        rsp_y_d   = rsp_y_q;
        rsp_id_d  = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    mul_a_d = grant[1] ? req1_a : req0_a;
                    mul_b_d = grant[1] ? req1_b : req0_b;
                    id_d    = ID_W'(grant[1]);
                    prio_d  = grant[0];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (run_last) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                rsp_y_d  = mul_ry;
                rsp_id_d = id_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        mul_ld_d    = (state_d == ST_LOAD);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
            id_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_ld_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_ld_q    <= mul_ld_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_ld    = mul_ld_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a behavioural shift-add multiplier attached.
// Stimulus pushes hand-computed products; a negedge monitor pops and compares responses.
module tb_mul_seq_ctrl;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic           req0_ready, req1_ready;
    logic           mul_ld;
    logic [W-1:0]   mul_a, mul_b, mul_rb;
    logic [2*W-1:0] mul_ry;
    logic           rsp_valid;
    logic [0:0]     rsp_id;
    logic [2*W-1:0] rsp_y;
    logic           rsp_ready = 1'b1;
    logic           busy;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .mul_ld     (mul_ld),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_rb     (mul_rb),
        .mul_ry     (mul_ry),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    // Shift-add multiplier: load on ld, otherwise one add/shift step per cycle.
    logic [2*W-1:0] m_ra = '0, m_ry = '0;
    logic [W-1:0]   m_rb = '0;
    always @(posedge clk) begin
        if (mul_ld) begin
            m_ra <= {{W{1'b0}}, mul_a};
            m_rb <= mul_b;
            m_ry <= '0;
        end else begin
            if (m_rb[0]) m_ry <= m_ry + m_ra;
            m_ra <= m_ra << 1;
            m_rb <= m_rb >> 1;
        end
    end
    assign mul_rb = m_rb;
    assign mul_ry = m_ry;

    typedef struct {
        logic           id;
        logic [2*W-1:0] y;
        int             due;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Cycles from accept edge to rsp_valid for a given multiplier operand.
    function automatic int expLat(input logic [W-1:0] b);
`ifdef MUL_EARLY_DONE_EN
        int run = 1;
        for (int k = 0; k < W; k++) if (b[k]) run = k + 2;
        if (run > W) run = W;
        return run + 2;
`else
        return W + 2;
`endif
    endfunction

    // Reference arbiter/idle model and response monitor.
    logic           model_idle = 1'b1;
    logic           model_prio = 1'b0;
    logic           seen = 1'b0;
    logic [2*W-1:0] held_y = '0;
    logic           held_id = 1'b0;
    logic [1:0]     exp_g;

    always @(negedge clk) begin
        if (rst) begin
            model_idle = 1'b1;
            model_prio = 1'b0;
            seen       = 1'b0;
        end else begin
            if (req0_valid || req1_valid) begin
                exp_g = 2'b00;
                if (model_idle) begin
                    if (req0_valid && req1_valid) exp_g = model_prio ? 2'b10 : 2'b01;
                    else if (req0_valid)          exp_g = 2'b01;
                    else                          exp_g = 2'b10;
                end
                checkOutput("req0_ready", 32'(req0_ready), 32'(exp_g[0]));
                checkOutput("req1_ready", 32'(req1_ready), 32'(exp_g[1]));
                if (exp_g != 2'b00) begin
                    model_idle = 1'b0;
                    model_prio = exp_g[0];
                end
            end
            if (rsp_valid) begin
                checkOutput("busy_in_resp", 32'(busy), 32'd1);
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    if (!seen) begin
                        checkOutput("latency_cycle", 32'(cyc), 32'(sbq[0].due));
                        seen    = 1'b1;
                        held_y  = rsp_y;
                        held_id = rsp_id[0];
                    end else begin
                        checkOutput("rsp_y_stable", 32'(rsp_y), 32'(held_y));
                        checkOutput("rsp_id_stable", 32'(rsp_id), 32'(held_id));
                    end
                    if (rsp_ready) begin
                        checkOutput("rsp_y", 32'(rsp_y), 32'(sbq[0].y));
                        checkOutput("rsp_id", 32'(rsp_id), 32'(sbq[0].id));
                        void'(sbq.pop_front());
                        seen       = 1'b0;
                        model_idle = 1'b1;
                    end
                end
            end
        end
    end

    // Drive one request, wait for its handshake, queue the expected response.
    task automatic applyStimulus(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2*W-1:0] y);
        int waited = 0;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        forever begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
            waited++;
            if (waited > 200) begin
                timeoutFail(id ? "req1_accept" : "req0_accept");
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
                return;
            end
        end
        sbq.push_back('{id: id, y: y, due: cyc + 1 + expLat(b)});
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeoutFail("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_mul_ld", 32'(mul_ld), 32'd0);
        checkOutput("reset_mul_a", 32'(mul_a), 32'd0);
        checkOutput("reset_mul_b", 32'(mul_b), 32'd0);
        checkOutput("reset_rsp_y", 32'(rsp_y), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
    endtask

    task automatic finishRun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    initial begin
        int n;
        resetDut();

        $display("[TB] single request 13*11");
        applyStimulus(1'b0, 4'd13, 4'd11, 8'd143);
        waitDrain();

        $display("[TB] simultaneous requests after reset");
        resetDut();
        fork
            applyStimulus(1'b0, 4'd3, 4'd5, 8'd15);
            applyStimulus(1'b1, 4'd7, 4'd9, 8'd63);
        join
        waitDrain();

        $display("[TB] req1 held, req0 pulsed");
        fork
            begin
                applyStimulus(1'b1, 4'd2, 4'd3, 8'd6);
                applyStimulus(1'b1, 4'd4, 4'd5, 8'd20);
                applyStimulus(1'b1, 4'd6, 4'd7, 8'd42);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                applyStimulus(1'b0, 4'd8, 4'd9, 8'd72);
            end
        join
        waitDrain();

        $display("[TB] back-pressure on 15*15");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'd15, 4'd15, 8'd225);
        fork
            applyStimulus(1'b1, 4'd5, 4'd6, 8'd30);
            begin
                n = 0;
                while (!rsp_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) timeoutFail("rsp_valid_backpressure");
                repeat (4) @(negedge clk);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] zero multiplier");
        applyStimulus(1'b0, 4'd9, 4'd0, 8'd0);
        waitDrain();

        $display("[TB] reset during RUN");
        applyStimulus(1'b0, 4'd6, 4'd7, 8'd42);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_mul_ld", 32'(mul_ld), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 4'd12, 4'd10, 8'd120);
        waitDrain();

        finishRun();
    end

    initial begin
        repeat (20000) @(posedge clk);
        timeoutFail("watchdog");
        finishRun();
    end

endmodule
